// File: rtl/acc_cpu_pkg.sv
// Shared opcode map, FSM state encoding and opcode classification helpers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package acc_cpu_pkg;

  localparam logic [7:0] OP_NOP    = 8'h00;
  localparam logic [7:0] OP_LDI    = 8'h01;
  localparam logic [7:0] OP_ADDI   = 8'h02;
  localparam logic [7:0] OP_SUBI   = 8'h03;
  localparam logic [7:0] OP_ANDI   = 8'h04;
  localparam logic [7:0] OP_ORI    = 8'h05;
  localparam logic [7:0] OP_XORI   = 8'h06;
  localparam logic [7:0] OP_NOT    = 8'h07;
  localparam logic [7:0] OP_SHL    = 8'h08;
  localparam logic [7:0] OP_SHR    = 8'h09;
  localparam logic [7:0] OP_HALT   = 8'h0A;
  localparam logic [7:0] OP_INR_A  = 8'h0E;
  localparam logic [7:0] OP_DCR_A  = 8'h0F;
  localparam logic [7:0] OP_MOV_RA = 8'h10;  // Rn <- A
  localparam logic [7:0] OP_MOV_AR = 8'h11;  // A <- Rn
  localparam logic [7:0] OP_ADD    = 8'h12;
  localparam logic [7:0] OP_SUB    = 8'h13;
  localparam logic [7:0] OP_INR_R  = 8'h14;
  localparam logic [7:0] OP_DCR_R  = 8'h15;
  localparam logic [7:0] OP_JMP    = 8'h20;
  localparam logic [7:0] OP_JZ     = 8'h21;
  localparam logic [7:0] OP_JNZ    = 8'h22;
  localparam logic [7:0] OP_JC     = 8'h23;
  localparam logic [7:0] OP_JNC    = 8'h24;
  localparam logic [7:0] OP_CALL   = 8'h30;
  localparam logic [7:0] OP_RET    = 8'h31;

  typedef enum logic [1:0] {FETCH, DECODE, EXECUTE, HALT} state_t;

  // Opcodes that carry an operand word fetched during DECODE.
  function automatic logic is_two_word(input logic [7:0] op);
    return (op >= OP_LDI    && op <= OP_XORI)  ||
           (op >= OP_MOV_RA && op <= OP_DCR_R) ||
           (op >= OP_JMP    && op <= OP_JNC)   ||
           (op == OP_CALL);
  endfunction

  // Anything outside the defined opcode map faults the core.
  function automatic logic is_legal(input logic [7:0] op);
    return is_two_word(op) || op == OP_NOP || op == OP_NOT || op == OP_SHL ||
           op == OP_SHR || op == OP_HALT || op == OP_INR_A || op == OP_DCR_A ||
           op == OP_RET;
  endfunction

endpackage

// File: rtl/acc_cpu_alu.sv
// Accumulator ALU: computes the result and new Z/C for one opcode.
// Latency: combinational, zero cycles.
// Backpressure: none; the result is consumed by the core during EXECUTE.
module acc_cpu_alu
  import acc_cpu_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [7:0]    op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic          c_in,
  output logic [DW-1:0] result,
  output logic          z,
  output logic          c,
  output logic          writes_a
);

  // Opcode-driven result and flag generation; ops that do not touch C pass c_in.
  // NOT is treated as a logic op and clears C like ANDI/ORI/XORI.
  always_comb begin
    result   = a;
    c        = c_in;
    writes_a = 1'b0;
    case (op)
      OP_LDI, OP_MOV_AR: begin result = b; writes_a = 1'b1; end
      OP_ADDI, OP_ADD:   begin {c, result} = {1'b0, a} + {1'b0, b}; writes_a = 1'b1; end
      OP_SUBI, OP_SUB:   begin result = a - b; c = (a < b); writes_a = 1'b1; end
      OP_ANDI:           begin result = a & b; c = 1'b0; writes_a = 1'b1; end
      OP_ORI:            begin result = a | b; c = 1'b0; writes_a = 1'b1; end
      OP_XORI:           begin result = a ^ b; c = 1'b0; writes_a = 1'b1; end
      OP_NOT:            begin result = ~a;    c = 1'b0; writes_a = 1'b1; end
      OP_SHL:            begin result = {a[DW-2:0], 1'b0}; c = a[DW-1]; writes_a = 1'b1; end
      OP_SHR:            begin result = {1'b0, a[DW-1:1]}; c = a[0];    writes_a = 1'b1; end
      OP_INR_A:          begin result = a + 1'b1; writes_a = 1'b1; end
      OP_DCR_A:          begin result = a - 1'b1; writes_a = 1'b1; end
      OP_INR_R:          result = b + 1'b1;
      OP_DCR_R:          result = b - 1'b1;
      default:           ;
    endcase
    z = (result == '0);
  end

endmodule

// File: rtl/acc_cpu_core.sv
// Accumulator CPU: 3-cycle FETCH/DECODE/EXECUTE FSM, program RAM, register file, return stack.
// Latency: every instruction takes exactly 3 enabled cycles; HALT is absorbing until reset.
// Backpressure: ena=0 or prog_we=1 freezes the FSM and all architectural state.
module acc_cpu_core
  import acc_cpu_pkg::*;
#(
  parameter  int DW          = 8,
  parameter  int IMEM_DEPTH  = 32,
  parameter  int NREGS       = 4,
  parameter  int STACK_DEPTH = 4,
  localparam int AW          = $clog2(IMEM_DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ena,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [DW-1:0] prog_data,
  output logic [DW-1:0] acc_out,
  output logic [AW-1:0] pc_out,
  output logic          flag_z,
  output logic          flag_c,
  output logic          halted,
  output logic          fault
);

  localparam int NW  = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam int SIW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int SPW = $clog2(STACK_DEPTH + 1);
  localparam logic [SPW-1:0] SP_FULL = SPW'(STACK_DEPTH);

  state_t          state, state_nxt;
  logic [DW-1:0]   mem   [IMEM_DEPTH];
  logic [DW-1:0]   regs  [NREGS];
  logic [AW-1:0]   stack [STACK_DEPTH];
  logic [AW-1:0]   pc;
  logic [DW-1:0]   acc;
  logic [7:0]      opcode;
  logic [DW-1:0]   operand;
  logic [SPW-1:0]  sp;
  logic            z_q, c_q, fault_q;

  logic            adv;
  logic [NW-1:0]   rn;
  logic [SPW-1:0]  sp_top;
  logic            exec_fault, take_jump, z_upd;
  logic [DW-1:0]   alu_b, alu_res;
  logic            alu_z, alu_c, alu_wa;

  assign adv    = ena & ~prog_we;
  assign rn     = operand[NW-1:0];
  assign sp_top = sp - 1'b1;

  assign exec_fault = !is_legal(opcode) ||
                      (opcode == OP_CALL && sp == SP_FULL) ||
                      (opcode == OP_RET  && sp == '0);

  // LDI and MOV write A without touching Z; INR/DCR Rn update Z from the register result.
  assign z_upd = (alu_wa && opcode != OP_LDI && opcode != OP_MOV_AR) ||
                 opcode == OP_INR_R || opcode == OP_DCR_R;

  assign alu_b = (opcode == OP_ADD || opcode == OP_SUB || opcode == OP_MOV_AR ||
                  opcode == OP_INR_R || opcode == OP_DCR_R) ? regs[rn] : operand;

  // Conditional branch resolution from the current flags.
  always_comb begin
    case (opcode)
      OP_JMP:  take_jump = 1'b1;
      OP_JZ:   take_jump = z_q;
      OP_JNZ:  take_jump = ~z_q;
      OP_JC:   take_jump = c_q;
      OP_JNC:  take_jump = ~c_q;
      default: take_jump = 1'b0;
    endcase
  end

  acc_cpu_alu #(.DW(DW)) u_alu (
    .op       (opcode),
    .a        (acc),
    .b        (alu_b),
    .c_in     (c_q),
    .result   (alu_res),
    .z        (alu_z),
    .c        (alu_c),
    .writes_a (alu_wa)
  );

  // Program RAM write port; deliberately not reset so programs survive rst_n.
  always_ff @(posedge clk) begin
    if (prog_we) mem[prog_addr] <= prog_data;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   state <= FETCH;
    else if (adv) state <= state_nxt;
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      FETCH:   state_nxt = DECODE;
      DECODE:  state_nxt = EXECUTE;
      EXECUTE: state_nxt = (exec_fault || opcode == OP_HALT) ? HALT : FETCH;
      HALT:    state_nxt = HALT;
      default: state_nxt = FETCH;
    endcase
  end

  // FSM outputs.
  always_comb begin
    halted = (state == HALT);
  end

  // Datapath: instruction/operand fetch, execute side effects, stack and fault capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc      <= '0;
      acc     <= '0;
      opcode  <= '0;
      operand <= '0;
      sp      <= '0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      fault_q <= 1'b0;
      for (int i = 0; i < NREGS; i++)       regs[i]  <= '0;
      for (int i = 0; i < STACK_DEPTH; i++) stack[i] <= '0;
    end else if (adv) begin
      case (state)
        FETCH: begin
          opcode <= mem[pc][7:0];
          pc     <= pc + 1'b1;
        end
        DECODE: begin
          if (is_two_word(opcode)) begin
            operand <= mem[pc];
            pc      <= pc + 1'b1;
          end
        end
        EXECUTE: begin
          if (exec_fault) begin
            fault_q <= 1'b1;
          end else begin
            if (alu_wa) acc <= alu_res;
            if (z_upd)  z_q <= alu_z;
            c_q <= alu_c;
            case (opcode)
              OP_MOV_RA:         regs[rn] <= acc;
              OP_INR_R, OP_DCR_R: regs[rn] <= alu_res;
              OP_JMP, OP_JZ, OP_JNZ, OP_JC, OP_JNC:
                if (take_jump) pc <= operand[AW-1:0];
              OP_CALL: begin
                stack[sp[SIW-1:0]] <= pc;
                sp <= sp + 1'b1;
                pc <= operand[AW-1:0];
              end
              OP_RET: begin
                pc <= stack[sp_top[SIW-1:0]];
                sp <= sp_top;
              end
              default: ;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

  assign acc_out = acc;
  assign pc_out  = pc;
  assign flag_z  = z_q;
  assign flag_c  = c_q;
  assign fault   = fault_q;

endmodule

// File: tb/tb_acc_cpu_core.sv
// Directed bench for acc_cpu_core: small programs with hand-computed final state.
// Latency: checks are taken on the falling edge after a known number of enabled cycles.
// Backpressure: exercises prog_we stall, ena stall and asynchronous reset mid-instruction.
module tb_acc_cpu_core;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       prog_we = 1'b0;
  logic [4:0] prog_addr = '0;
  logic [7:0] prog_data = '0;
  logic [7:0] acc_out;
  logic [4:0] pc_out;
  logic       flag_z, flag_c, halted, fault;

  int n_cmp = 0;
  int n_err = 0;

  acc_cpu_core #(.DW(8), .IMEM_DEPTH(32), .NREGS(4), .STACK_DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .acc_out   (acc_out),
    .pc_out    (pc_out),
    .flag_z    (flag_z),
    .flag_c    (flag_c),
    .halted    (halted),
    .fault     (fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Hold the core in reset with ena low; programs are loaded while reset is asserted.
  task automatic begin_prog();
    @(negedge clk);
    ena   = 1'b0;
    rst_n = 1'b0;
  endtask

  task automatic wr(input logic [4:0] addr, input logic [7:0] d);
    prog_we   = 1'b1;
    prog_addr = addr;
    prog_data = d;
    @(negedge clk);
    prog_we   = 1'b0;
  endtask

  task automatic end_prog();
    rst_n = 1'b1;
  endtask

  // ena high for exactly n rising edges, ending on a falling edge.
  task automatic run(input int n);
    ena = 1'b1;
    repeat (n) @(negedge clk);
    ena = 1'b0;
  endtask

  initial begin
    // Reset state.
    @(negedge clk);
    check("rst_acc", acc_out, 8'h00);
    check("rst_pc", pc_out, 5'd0);
    check("rst_flags", {flag_z, flag_c}, 2'b00);
    check("rst_halt", {halted, fault}, 2'b00);

    // T1: LDI 05; ADDI FE; HALT -> A=03, C=1.
    begin_prog();
    wr(0, 8'h01); wr(1, 8'h05); wr(2, 8'h02); wr(3, 8'hFE); wr(4, 8'h0A);
    end_prog();
    run(8);
    check("t1_not_yet_halted", halted, 1'b0);
    run(1);
    check("t1_halted", halted, 1'b1);
    check("t1_acc", acc_out, 8'h03);
    check("t1_c", flag_c, 1'b1);
    check("t1_z", flag_z, 1'b0);
    check("t1_fault", fault, 1'b0);

    // T2: countdown loop with JNZ, 3 iterations.
    begin_prog();
    wr(0, 8'h01); wr(1, 8'h03); wr(2, 8'h0F); wr(3, 8'h22); wr(4, 8'h02); wr(5, 8'h0A);
    end_prog();
    run(24);
    check("t2_halted", halted, 1'b1);
    check("t2_acc", acc_out, 8'h00);
    check("t2_z", flag_z, 1'b1);
    check("t2_pc", pc_out, 5'd6);

    // T3: CALL 5 -> NOP, INR A, RET -> HALT at 2.
    begin_prog();
    wr(0, 8'h30); wr(1, 8'h05); wr(2, 8'h0A); wr(3, 8'h00); wr(4, 8'h00);
    wr(5, 8'h00); wr(6, 8'h0E); wr(7, 8'h31);
    end_prog();
    run(15);
    check("t3_halted", halted, 1'b1);
    check("t3_acc", acc_out, 8'h01);
    check("t3_fault", fault, 1'b0);
    check("t3_pc", pc_out, 5'd3);

    // T4a: CALL to self overflows the 4-deep stack on the fifth call.
    begin_prog();
    wr(0, 8'h30); wr(1, 8'h00);
    end_prog();
    run(12);
    check("t4a_four_calls_ok", halted, 1'b0);
    run(3);
    check("t4a_halt_fault", {halted, fault}, 2'b11);
    check("t4a_pc", pc_out, 5'd2);

    // T4b: RET with empty stack.
    begin_prog();
    wr(0, 8'h31);
    end_prog();
    run(3);
    check("t4b_halt_fault", {halted, fault}, 2'b11);
    check("t4b_pc", pc_out, 5'd1);

    // T5: illegal opcode after LDI AA.
    begin_prog();
    wr(0, 8'h01); wr(1, 8'hAA); wr(2, 8'hFF);
    end_prog();
    run(6);
    check("t5_halt_fault", {halted, fault}, 2'b11);
    check("t5_acc", acc_out, 8'hAA);
    check("t5_flags", {flag_z, flag_c}, 2'b00);
    check("t5_pc", pc_out, 5'd3);

    // T7: LDI 81; SHL (A=02,C=1); MOV R1<-A; LDI 05; SUB R1 (03,C=0); SUBI 04 (FF,C=1); HALT.
    begin_prog();
    wr(0, 8'h01); wr(1, 8'h81); wr(2, 8'h08); wr(3, 8'h10); wr(4, 8'h01);
    wr(5, 8'h01); wr(6, 8'h05); wr(7, 8'h13); wr(8, 8'h05); wr(9, 8'h03);
    wr(10, 8'h04); wr(11, 8'h0A);
    end_prog();
    run(6);
    check("t7_shl_acc", acc_out, 8'h02);
    check("t7_shl_c", flag_c, 1'b1);
    run(9);
    check("t7_sub_acc", acc_out, 8'h03);
    check("t7_sub_c", flag_c, 1'b0);
    run(6);
    check("t7_subi_acc", acc_out, 8'hFF);
    check("t7_subi_flags", {flag_z, flag_c}, 2'b01);
    check("t7_halt", {halted, fault, pc_out}, {1'b1, 1'b0, 5'd12});

    // T6: prog_we stall in DECODE, ena stall, async reset in EXECUTE, rerun.
    begin_prog();
    wr(0, 8'h01); wr(1, 8'h05); wr(2, 8'h02); wr(3, 8'hFE); wr(4, 8'h0A);
    end_prog();
    run(1);
    ena = 1'b1;
    wr(20, 8'h55);
    check("t6_we_pc_frozen", pc_out, 5'd1);
    check("t6_we_acc_frozen", acc_out, 8'h00);
    run(2);
    check("t6_ldi_acc", acc_out, 8'h05);
    check("t6_ldi_pc", pc_out, 5'd2);
    run(0);
    @(negedge clk);
    check("t6_ena_stall_pc", pc_out, 5'd2);
    run(2);
    check("t6_mid_pc", pc_out, 5'd4);
    rst_n = 1'b0;
    #1;
    check("t6_arst_acc_pc", {acc_out, pc_out}, 13'h0);
    check("t6_arst_flags", {flag_z, flag_c, halted, fault}, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run(9);
    check("t6_rerun_acc", acc_out, 8'h03);
    check("t6_rerun_c_halt", {flag_c, halted, fault}, 3'b110);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
